decode_arbiter: RTL and testbench
=================================

# decode_arbiter

Round-robin arbiter that shares a single 2-to-4 decoder among four requesters. It picks one requester, drives the decoder select inputs with that requester's index, and holds the grant until the owner releases it, drops its request, or hits a hold-time limit. It sits directly in front of the `decode` block. Output `a` feeds decoder input `a` (MSB), output `b` feeds decoder input `b` (LSB), and the selected decoder output is d{a,b}.

## Interface
- HOLD_MAX, default 8: maximum consecutive cycles one grant may last. 0 disables the timeout. Legal range 0..255.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines; req[i] is requester i.
- done  input  1  owner releases the grant; sampled only in GRANT.
- a  output  1  select MSB to decoder (owner index bit 1).
- b  output  1  select LSB to decoder (owner index bit 0).
- gnt_valid  output  1  high while a grant is active; the decoder outputs are meaningful only when this is high.
- tmo  output  1  one-cycle pulse: the previous grant was force-released by timeout.

## Operation
- All outputs are registered.
- Reset values:
  - state IDLE
  - a=0, b=0
  - gnt_valid=0, tmo=0
  - hold counter 0
  - last-owner pointer = 3, so requester 0 has first priority.
- States are IDLE and GRANT.
- IDLE behaviour:
  - If req==0, stay in IDLE. a/b hold their last values. gnt_valid=0.
  - Otherwise choose the first set req[i] scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Load {a,b}=i, set gnt_valid=1, set ptr=i, set counter=1, go to GRANT.
- GRANT behaviour, with owner = {a,b}:
  - Release when done=1, or req[owner]=0, or (HOLD_MAX!=0 and counter==HOLD_MAX).
  - On release: go to IDLE, gnt_valid=0, a/b unchanged, counter=0.
  - If the release is due to timeout only (done=0 and req[owner]=1), set tmo=1 for the next cycle.
  - Otherwise stay in GRANT with counter+1. The counter saturates at 255.
- tmo is 1 only in the first IDLE cycle after a timeout release, and 0 everywhere else.
- Release condition priority: done and req-drop take precedence over timeout. If a release coincides with counter==HOLD_MAX and done=1 or req[owner]=0, there is no tmo pulse.
- Requests from non-owners during GRANT are ignored; they are queued only by their level.
- The released owner gets lowest priority in the next arbitration. This guarantees no starvation: any held request is granted within 3 foreign grants.
- rst in any state returns all registers to their reset values on that edge. An in-flight grant is dropped without a tmo pulse.

## Timing
- Grant latency: req sampled at edge k in IDLE gives gnt_valid=1 and valid a/b after edge k.
- Release: release condition sampled at edge k gives gnt_valid=0 after edge k.
- Dead cycle: at least one cycle with gnt_valid=0 between any two grants. Back-to-back arbitration is therefore a 2-cycle minimum period per grant.
- Timeout: with HOLD_MAX=N, gnt_valid is high for exactly N cycles when never released. tmo is high in the cycle right after, and the earliest re-grant is the edge after that.
- a/b never change while gnt_valid=1.

## Test plan
- Reset check:
  - Stimulus: rst=1 for 2 cycles with req=4'b1111.
  - Required: gnt_valid=0, a=0, b=0, tmo=0 throughout.
  - After rst drops: first grant is requester 0 (a=0, b=0) one edge later.
- Round robin:
  - Stimulus: req=4'b0101 held; pulse done for one cycle in each grant.
  - Required: grants alternate 0 (a=0,b=0), 2 (a=1,b=0), 0, 2.
  - Each grant is separated by exactly one gnt_valid=0 cycle.
- Request drop:
  - Stimulus: req=4'b1000 until granted (a=1,b=1); hold 3 cycles, then req=0.
  - Required: gnt_valid falls on the edge after the drop; no tmo; state stays IDLE.
- Timeout, HOLD_MAX=4:
  - Stimulus: req=4'b0001 held, done=0.
  - Required: gnt_valid high exactly 4 cycles, then one cycle of gnt_valid=0 with tmo=1, then requester 0 re-granted.
  - Repeat with done=1 in the 4th cycle: no tmo.
- Fairness:
  - Stimulus: req=4'b1111, done pulsed each grant.
  - Required: grant order 0,1,2,3,0. a/b stable during each gnt_valid window.
- Reset mid-grant:
  - Stimulus: rst=1 for one cycle while requester 2 is granted, with req=4'b0100 still held.
  - Required: gnt_valid=0 and a=b=0 after that edge, tmo=0.
  - Requester 2 is re-granted one edge after rst falls.

Source files
------------

// File: rtl/decode_arbiter.sv
// Round-robin arbiter sharing one 2-to-4 decoder among four requesters.
// The owner index is driven on {a,b}. A grant ends on done, on a dropped request, or on a hold-time limit.
module decode_arbiter #(
   parameter int unsigned HOLD_MAX = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       done,
   output logic       a,
   output logic       b,
   output logic       gnt_valid,
   output logic       tmo
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
   localparam bit         TMO_EN   = (HOLD_MAX != 0);

   state_e     state_q;
   logic       a_q;
   logic       b_q;
   logic       gnt_q;
   logic       tmo_q;
   logic [7:0] cnt_q;
   logic [1:0] ptr_q;

   logic [1:0] cand     [4];
   logic [3:0] cand_hit;
   logic [1:0] pick_d;
   logic       pick_any;
   logic [1:0] owner;
   logic       rel_user;
   logic       rel_tmo;
   logic [7:0] cnt_d;

   // Candidate k is ptr+k+1 (mod 4), so the last owner is scanned last.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_cand
         assign cand[gi]     = ptr_q + 2'(gi + 1);
         assign cand_hit[gi] = req[cand[gi]];
      end
   endgenerate

   always_comb begin
      pick_d   = ptr_q;
      pick_any = |req;
      for (int k = 3; k >= 0; k--) begin
         if (cand_hit[k]) begin
            pick_d = cand[k];
         end
      end
   end

   assign owner    = {a_q, b_q};
   assign rel_user = done | ~req[owner];
   assign rel_tmo  = TMO_EN && (cnt_q == HOLD_LIM);
   assign cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         gnt_q   <= 1'b0;
         tmo_q   <= 1'b0;
         cnt_q   <= 8'd0;
         ptr_q   <= 2'd3;
      end else begin
         tmo_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  {a_q, b_q} <= pick_d;
                  ptr_q      <= pick_d;
                  gnt_q      <= 1'b1;
                  cnt_q      <= 8'd1;
                  state_q    <= GRANT;
               end else begin
                  gnt_q <= 1'b0;
               end
            end
            GRANT: begin
               // done and a dropped request outrank the timeout, so no tmo then.
               if (rel_user || rel_tmo) begin
                  state_q <= IDLE;
                  gnt_q   <= 1'b0;
                  cnt_q   <= 8'd0;
                  tmo_q   <= ~rel_user;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= 1'b0;
               cnt_q   <= 8'd0;
            end
         endcase
      end
   end

   assign a         = a_q;
   assign b         = b_q;
   assign gnt_valid = gnt_q;
   assign tmo       = tmo_q;

endmodule

// File: tb/tb_decode_arbiter.sv
// Directed bench for decode_arbiter with HOLD_MAX=4; observes {gnt_valid,a,b,tmo} 1ns after each rising edge.
module tb_decode_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       done;
   logic       a;
   logic       b;
   logic       gnt_valid;
   logic       tmo;

   int checks;
   int failures;
   logic [3:0] obs;
   logic [3:0] exp_v;

   decode_arbiter #(.HOLD_MAX(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .a         (a),
      .b         (b),
      .gnt_valid (gnt_valid),
      .tmo       (tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      req  = 4'b0000;
      done = 1'b0;
      tick();
      rst  = 1'b0;
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      req  = 4'b1111;
      done = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         obs = {gnt_valid, a, b, tmo};
         checks++;
         if (obs !== 4'b0000) begin
            failures++;
            $display("FAIL reset_hold[%0d]: got %b expected 0000", i, obs);
         end
         $display("reset cycle %0d: {gnt,a,b,tmo}=%b", i, obs);
      end
      rst = 1'b0;
      tick();
      obs = {gnt_valid, a, b, tmo};
      checks++;
      if (obs !== 4'b1000) begin
         failures++;
         $display("FAIL reset_first_grant: got %b expected 1000", obs);
      end
      $display("reset release first grant: %b", obs);
      req = 4'b0000;
      tick();
      obs = {gnt_valid, a, b, tmo};
      checks++;
      if (obs !== 4'b0000) begin
         failures++;
         $display("FAIL reset_drop: got %b expected 0000", obs);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_ab [4];
      exp_ab[0] = 2'd0; exp_ab[1] = 2'd2; exp_ab[2] = 2'd0; exp_ab[3] = 2'd2;
      do_reset();
      req = 4'b0101;
      for (int g = 0; g < 4; g++) begin
         tick();
         obs   = {gnt_valid, a, b, tmo};
         exp_v = {1'b1, exp_ab[g], 1'b0};
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL rr_grant[%0d]: got %b expected %b", g, obs, exp_v);
         end
         $display("round robin grant %0d: %b", g, obs);
         done = 1'b1;
         tick();
         done = 1'b0;
         obs  = {gnt_valid, a, b, tmo};
         exp_v = {1'b0, exp_ab[g], 1'b0};
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL rr_gap[%0d]: got %b expected %b", g, obs, exp_v);
         end
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_req_drop();
      do_reset();
      req = 4'b1000;
      for (int i = 0; i < 3; i++) begin
         tick();
         obs = {gnt_valid, a, b, tmo};
         checks++;
         if (obs !== 4'b1110) begin
            failures++;
            $display("FAIL drop_hold[%0d]: got %b expected 1110", i, obs);
         end
      end
      req = 4'b0000;
      for (int i = 0; i < 2; i++) begin
         tick();
         obs = {gnt_valid, a, b, tmo};
         checks++;
         if (obs !== 4'b0110) begin
            failures++;
            $display("FAIL drop_idle[%0d]: got %b expected 0110", i, obs);
         end
         $display("request drop idle %0d: %b", i, obs);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      req = 4'b0001;
      for (int i = 1; i <= 4; i++) begin
         tick();
         obs = {gnt_valid, a, b, tmo};
         checks++;
         if (obs !== 4'b1000) begin
            failures++;
            $display("FAIL tmo_window[%0d]: got %b expected 1000", i, obs);
         end
      end
      tick();
      obs = {gnt_valid, a, b, tmo};
      checks++;
      if (obs !== 4'b0001) begin
         failures++;
         $display("FAIL tmo_pulse: got %b expected 0001", obs);
      end
      $display("timeout pulse: %b", obs);
      // Re-grant, then release with done exactly when the counter reaches the limit.
      for (int i = 1; i <= 4; i++) begin
         tick();
         obs = {gnt_valid, a, b, tmo};
         checks++;
         if (obs !== 4'b1000) begin
            failures++;
            $display("FAIL tmo_regrant[%0d]: got %b expected 1000", i, obs);
         end
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      obs  = {gnt_valid, a, b, tmo};
      checks++;
      if (obs !== 4'b0000) begin
         failures++;
         $display("FAIL tmo_done_priority: got %b expected 0000", obs);
      end
      $display("done at limit: %b", obs);
      tick();
      obs = {gnt_valid, a, b, tmo};
      checks++;
      if (obs !== 4'b1000) begin
         failures++;
         $display("FAIL tmo_after_done: got %b expected 1000", obs);
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_fairness();
      logic [1:0] exp_ab [5];
      exp_ab[0] = 2'd0; exp_ab[1] = 2'd1; exp_ab[2] = 2'd2;
      exp_ab[3] = 2'd3; exp_ab[4] = 2'd0;
      do_reset();
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         exp_v = {1'b1, exp_ab[g], 1'b0};
         for (int c = 0; c < 2; c++) begin
            tick();
            obs = {gnt_valid, a, b, tmo};
            checks++;
            if (obs !== exp_v) begin
               failures++;
               $display("FAIL fair_grant[%0d.%0d]: got %b expected %b", g, c, obs, exp_v);
            end
         end
         $display("fairness grant %0d: %b", g, obs);
         done = 1'b1;
         tick();
         done = 1'b0;
         obs  = {gnt_valid, a, b, tmo};
         checks++;
         if (obs[3] !== 1'b0 || obs[0] !== 1'b0) begin
            failures++;
            $display("FAIL fair_gap[%0d]: got %b expected 0xx0", g, obs);
         end
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      req = 4'b0100;
      tick();
      obs = {gnt_valid, a, b, tmo};
      checks++;
      if (obs !== 4'b1100) begin
         failures++;
         $display("FAIL mid_grant: got %b expected 1100", obs);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      obs = {gnt_valid, a, b, tmo};
      checks++;
      if (obs !== 4'b0000) begin
         failures++;
         $display("FAIL mid_reset: got %b expected 0000", obs);
      end
      $display("reset mid-grant: %b", obs);
      tick();
      obs = {gnt_valid, a, b, tmo};
      checks++;
      if (obs !== 4'b1100) begin
         failures++;
         $display("FAIL mid_regrant: got %b expected 1100", obs);
      end
      req = 4'b0000;
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      req      = 4'b0000;
      done     = 1'b0;
      test_reset();
      test_round_robin();
      test_req_drop();
      test_timeout();
      test_fairness();
      test_reset_mid_grant();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
